// File: rtl/alu_sequencer_if.sv
// Bus bundle between the ALU sequencer and its FIFO_IN, ALU and FIFO_OUT neighbours.
`timescale 1ns/1ps
interface alu_sequencer_if #(
  parameter int OPERATION_SIZE = 2,
  parameter int DATA_SIZE      = 12,
  parameter int FIFO_OUT_WIDTH = 25
);
  logic                                  empty_in;
  logic [OPERATION_SIZE+2*DATA_SIZE-1:0] fifo_in_data;
  logic                                  r_en_in;
  logic                                  alu_start;
  logic [OPERATION_SIZE-1:0]             alu_op;
  logic [DATA_SIZE-1:0]                  alu_a;
  logic [DATA_SIZE-1:0]                  alu_b;
  logic                                  alu_done;
  logic [2*DATA_SIZE-1:0]                alu_result;
  logic                                  alu_ovf;
  logic                                  full_out;
  logic                                  w_en_out;
  logic [FIFO_OUT_WIDTH-1:0]             fifo_out_data;

  modport master (
    input  empty_in, fifo_in_data, alu_done, alu_result, alu_ovf, full_out,
    output r_en_in, alu_start, alu_op, alu_a, alu_b, w_en_out, fifo_out_data
  );

  modport slave (
    output empty_in, fifo_in_data, alu_done, alu_result, alu_ovf, full_out,
    input  r_en_in, alu_start, alu_op, alu_a, alu_b, w_en_out, fifo_out_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Pops one {op, data0, data1} entry, runs the ALU under a watchdog and pushes
// an {err, result} word to FIFO_OUT, counting completed operations.
`timescale 1ns/1ps
module alu_sequencer #(
  parameter int OPERATION_SIZE = 2,
  parameter int DATA_SIZE      = 12,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  alu_sequencer_if.master        bus,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] op_count
);
  localparam int IN_W  = OPERATION_SIZE + 2 * DATA_SIZE;
  localparam int RES_W = 2 * DATA_SIZE;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_EXEC, S_WAIT, S_PUSH} state_t;

  function automatic logic op_legal(input logic [OPERATION_SIZE-1:0] op);
    return (op == OPERATION_SIZE'(1)) || (op == OPERATION_SIZE'(2));
  endfunction

  state_t                      state_q, state_d;
  logic [TO_W-1:0]             to_cnt_q;
  logic [FIFO_OUT_WIDTH-1:0]   res_q, res_d;
  logic [OPERATION_SIZE-1:0]   op_q;
  logic [DATA_SIZE-1:0]        a_q, b_q;
  logic [COUNT_WIDTH-1:0]      count_q;
  logic                        busy_q;
  logic                        r_en, start, w_en, load_op, load_res;
  logic [OPERATION_SIZE-1:0]   in_op;
  logic [DATA_SIZE-1:0]        in_a, in_b;

  assign in_op = bus.fifo_in_data[IN_W-1 -: OPERATION_SIZE];
  assign in_a  = bus.fifo_in_data[RES_W-1 -: DATA_SIZE];
  assign in_b  = bus.fifo_in_data[DATA_SIZE-1:0];

  always_comb begin
    state_d  = state_q;
    r_en     = 1'b0;
    start    = 1'b0;
    w_en     = 1'b0;
    load_op  = 1'b0;
    load_res = 1'b0;
    res_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (enable && !bus.empty_in) begin
          r_en    = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        load_op = 1'b1;
        if (op_legal(in_op)) begin
          state_d = S_EXEC;
        end else begin
          load_res = 1'b1;
          res_d    = FIFO_OUT_WIDTH'({1'b1, {RES_W{1'b0}}});
          state_d  = S_PUSH;
        end
      end
      S_EXEC: begin
        start   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last watchdog cycle still takes priority.
        if (bus.alu_done) begin
          load_res = 1'b1;
          res_d    = FIFO_OUT_WIDTH'({bus.alu_ovf, bus.alu_result});
          state_d  = S_PUSH;
        end else if (to_cnt_q == TO_LAST) begin
          load_res = 1'b1;
          res_d    = FIFO_OUT_WIDTH'({1'b1, {RES_W{1'b0}}});
          state_d  = S_PUSH;
        end
      end
      S_PUSH: begin
        if (!bus.full_out) begin
          w_en    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      res_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      if (load_op) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
      if (load_res) res_q <= res_d;
      if (state_q == S_EXEC) begin
        to_cnt_q <= '0;
      end else if (state_q == S_WAIT && !bus.alu_done) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
      if (w_en) count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  // The read pulse is held off while reset is asserted so every output reads 0.
  assign bus.r_en_in       = r_en & rst_n;
  assign bus.alu_start     = start;
  assign bus.alu_op        = op_q;
  assign bus.alu_a         = a_q;
  assign bus.alu_b         = b_q;
  assign bus.w_en_out      = w_en;
  assign bus.fifo_out_data = res_q;
  assign busy              = busy_q;
  assign op_count          = count_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with behavioural FIFO_IN and ALU models.
`timescale 1ns/1ps
module tb_alu_sequencer;
  localparam int OS = 2;
  localparam int DS = 12;
  localparam int OW = 25;
  localparam int TC = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          busy;
  logic [CW-1:0] op_count;

  alu_sequencer_if #(.OPERATION_SIZE(OS), .DATA_SIZE(DS), .FIFO_OUT_WIDTH(OW)) bus ();

  alu_sequencer #(
    .OPERATION_SIZE(OS), .DATA_SIZE(DS), .FIFO_OUT_WIDTH(OW),
    .TIMEOUT_CYCLES(TC), .COUNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [CW-1:0] exp_count = '0;

  logic [OS+2*DS-1:0] in_q[$];
  logic [OW-1:0]      exp_q[$];
  logic [OW-1:0]      push_q[$];
  int push_cyc_q[$];
  int ren_cyc_q[$];
  int start_cyc_q[$];
  int busy_rise_q[$];
  logic ren_s = 1'b0;
  logic start_s = 1'b0;
  logic busy_prev = 1'b0;

  int   alu_delay = 1;
  logic alu_ovf_cfg = 1'b0;
  int   alu_timer = 0;

  always @(posedge clk) cyc++;

  // Observation of DUT outputs, away from the active edge.
  always @(negedge clk) begin
    ren_s   = bus.r_en_in;
    start_s = bus.alu_start;
    if (bus.r_en_in) ren_cyc_q.push_back(cyc);
    if (bus.alu_start) start_cyc_q.push_back(cyc);
    if (bus.w_en_out) begin
      push_q.push_back(bus.fifo_out_data);
      push_cyc_q.push_back(cyc);
    end
    if (busy && !busy_prev) busy_rise_q.push_back(cyc);
    busy_prev = busy;
  end

  // FIFO_IN: read data appears the cycle after the read pulse.
  always @(posedge clk) begin
    #1;
    if (ren_s && in_q.size() > 0) bus.fifo_in_data = in_q.pop_front();
    bus.empty_in = (in_q.size() == 0);
  end

  // ALU: done alu_delay cycles after alu_start; alu_delay 0 never answers.
  always @(posedge clk) begin
    #1;
    bus.alu_done = 1'b0;
    if (!rst_n) begin
      alu_timer = 0;
    end else begin
      if (start_s && alu_delay > 0) alu_timer = alu_delay;
      if (alu_timer > 0) begin
        alu_timer--;
        if (alu_timer == 0) begin
          bus.alu_done = 1'b1;
          bus.alu_ovf  = alu_ovf_cfg;
          if (bus.alu_op == 2'b10) bus.alu_result = {12'h000, bus.alu_a} * {12'h000, bus.alu_b};
          else                     bus.alu_result = {12'h000, bus.alu_a} + {12'h000, bus.alu_b};
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_pushes(input int n, input int budget, output bit ok);
    int k = 0;
    while (push_q.size() < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    ok = (push_q.size() >= n);
  endtask

  task automatic wait_ren(input int n, input int budget, output bit ok);
    int k = 0;
    while (ren_cyc_q.size() < n && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    ok = (ren_cyc_q.size() >= n);
  endtask

  task automatic clear_logs();
    ren_cyc_q.delete();
    start_cyc_q.delete();
    push_cyc_q.delete();
    busy_rise_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    bus.full_out = 1'b0;
    tick(3);
    n_cmp++;
    if ({bus.r_en_in, bus.alu_start, bus.w_en_out} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b want 000", {bus.r_en_in, bus.alu_start, bus.w_en_out});
    end
    n_cmp++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 26'h0) begin
      n_fail++;
      $display("FAIL reset_operands: got %h want 0", {bus.alu_op, bus.alu_a, bus.alu_b});
    end
    n_cmp++;
    if (bus.fifo_out_data !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_fifo_out_data: got %h want 0", bus.fifo_out_data);
    end
    n_cmp++;
    if ({busy, op_count} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_busy_count: got %b want 000", {busy, op_count});
    end
    enable = 1'b1;
    in_q.push_back({2'b01, 12'h005, 12'h003});
    tick(2);
    n_cmp++;
    if (bus.r_en_in !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ren_held: got %b want 0", bus.r_en_in);
    end
    in_q.delete();
    enable = 1'b0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_add();
    bit ok;
    int t_ren;
    logic [OW-1:0] got, exp;
    clear_logs();
    enable = 1'b1;
    in_q.push_back({2'b01, 12'h005, 12'h003});
    exp_q.push_back(25'h0000008);
    exp_count = exp_count + 1'b1;
    wait_pushes(1, 30, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL add_push_seen: got %0d pushes want 1", push_q.size());
    end else begin
      got = push_q.pop_front();
      exp = exp_q.pop_front();
      t_ren = (ren_cyc_q.size() > 0) ? ren_cyc_q[0] : -100;
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL add_data: got %h want %h", got, exp);
      end
      n_cmp++;
      if (start_cyc_q.size() != 1 || start_cyc_q[0] - t_ren != 2) begin
        n_fail++;
        $display("FAIL add_start_latency: got %0d starts, first at +%0d, want 1 at +2",
                 start_cyc_q.size(), (start_cyc_q.size() > 0) ? start_cyc_q[0] - t_ren : -1);
      end
      n_cmp++;
      if (push_cyc_q[0] - t_ren != 4) begin
        n_fail++;
        $display("FAIL add_push_latency: got +%0d want +4", push_cyc_q[0] - t_ren);
      end
      n_cmp++;
      if (busy_rise_q.size() != 1 || busy_rise_q[0] - t_ren != 1) begin
        n_fail++;
        $display("FAIL add_busy_rise: got %0d rises want 1 at +1", busy_rise_q.size());
      end
    end
    n_cmp++;
    if ({busy, op_count} !== {1'b0, exp_count}) begin
      n_fail++;
      $display("FAIL add_count_busy: got %b want %b", {busy, op_count}, {1'b0, exp_count});
    end
    n_cmp++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b} !== {2'b01, 12'h005, 12'h003}) begin
      n_fail++;
      $display("FAIL add_latched_operands: got %h want %h",
               {bus.alu_op, bus.alu_a, bus.alu_b}, {2'b01, 12'h005, 12'h003});
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int t_ren;
    logic [OW-1:0] got, exp;
    clear_logs();
    in_q.push_back({2'b11, 12'h001, 12'h001});
    exp_q.push_back(25'h1000000);
    exp_count = exp_count + 1'b1;
    wait_pushes(1, 30, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL illegal_push_seen: got %0d pushes want 1", push_q.size());
    end else begin
      got = push_q.pop_front();
      exp = exp_q.pop_front();
      t_ren = (ren_cyc_q.size() > 0) ? ren_cyc_q[0] : -100;
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL illegal_data: got %h want %h", got, exp);
      end
      n_cmp++;
      if (push_cyc_q[0] - t_ren != 2) begin
        n_fail++;
        $display("FAIL illegal_push_latency: got +%0d want +2", push_cyc_q[0] - t_ren);
      end
    end
    n_cmp++;
    if (start_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL illegal_no_start: got %0d starts want 0", start_cyc_q.size());
    end
    n_cmp++;
    if (op_count !== exp_count) begin
      n_fail++;
      $display("FAIL illegal_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_timeout(input int delay, input logic ovf, input logic [OW-1:0] exp_word,
                              input logic [11:0] a, input logic [11:0] b);
    bit ok;
    int t_ren;
    logic [OW-1:0] got, exp;
    clear_logs();
    alu_delay = delay;
    alu_ovf_cfg = ovf;
    in_q.push_back({2'b01, a, b});
    exp_q.push_back(exp_word);
    exp_count = exp_count + 1'b1;
    wait_pushes(1, 60, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_push_seen: delay %0d got %0d pushes want 1", delay, push_q.size());
    end else begin
      got = push_q.pop_front();
      exp = exp_q.pop_front();
      t_ren = (ren_cyc_q.size() > 0) ? ren_cyc_q[0] : -100;
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL timeout_data: delay %0d got %h want %h", delay, got, exp);
      end
      n_cmp++;
      if (push_cyc_q[0] - t_ren != TC + 3) begin
        n_fail++;
        $display("FAIL timeout_push_cycle: delay %0d got +%0d want +%0d", delay, push_cyc_q[0] - t_ren, TC + 3);
      end
    end
    tick(1);
    n_cmp++;
    if (op_count !== exp_count) begin
      n_fail++;
      $display("FAIL timeout_count: got %0d want %0d", op_count, exp_count);
    end
    alu_delay = 1;
    alu_ovf_cfg = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    bit held_ok = 1'b1;
    int t_ren, t_fall, n0;
    logic [OW-1:0] got, exp;
    clear_logs();
    bus.full_out = 1'b1;
    in_q.push_back({2'b10, 12'h003, 12'h004});
    exp = 25'h000000C;
    exp_q.push_back(exp);
    exp_count = exp_count + 1'b1;
    wait_ren(1, 30, ok);
    t_ren = ok ? ren_cyc_q[0] : cyc;
    while (cyc < t_ren + 4) tick(1);
    repeat (10) begin
      @(negedge clk);
      #1;
      if (bus.w_en_out !== 1'b0 || bus.fifo_out_data !== exp) held_ok = 1'b0;
    end
    n_cmp++;
    if (!held_ok || push_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_hold: got held_ok=%0d pushes=%0d want 1 and 0", held_ok, push_q.size());
    end
    @(posedge clk);
    #2;
    bus.full_out = 1'b0;
    t_fall = cyc;
    wait_pushes(1, 10, ok);
    n_cmp++;
    if (!ok || push_cyc_q[0] != t_fall) begin
      n_fail++;
      $display("FAIL bp_release_cycle: got %0d want %0d", ok ? push_cyc_q[0] : -1, t_fall);
    end
    tick(5);
    n0 = push_q.size();
    n_cmp++;
    if (n0 != 1) begin
      n_fail++;
      $display("FAIL bp_single_push: got %0d pushes want 1", n0);
    end
    if (n0 > 0) begin
      got = push_q.pop_front();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL bp_data: got %h want %h", got, exp);
      end
    end
    push_q.delete();
  endtask

  task automatic test_stream_wrap();
    bit ok;
    bit gap_ok = 1'b1;
    logic [11:0] sa[5] = '{12'hFFF, 12'h002, 12'h010, 12'hABC, 12'h123};
    logic [11:0] sb[5] = '{12'hFFF, 12'h003, 12'h010, 12'h002, 12'h010};
    logic [23:0] sp[5] = '{24'hFFE001, 24'h000006, 24'h000100, 24'h001578, 24'h001230};
    logic [OW-1:0] got, exp;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      in_q.push_back({2'b10, sa[i], sb[i]});
      exp_q.push_back({1'b0, sp[i]});
      exp_count = exp_count + 1'b1;
    end
    wait_pushes(5, 80, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stream_push_seen: got %0d pushes want 5", push_q.size());
    end
    for (int i = 1; i < push_cyc_q.size(); i++)
      if (push_cyc_q[i] - push_cyc_q[i-1] != 5) gap_ok = 1'b0;
    n_cmp++;
    if (!gap_ok) begin
      n_fail++;
      $display("FAIL stream_back_to_back: got non-5-cycle spacing want 5");
    end
    while (push_q.size() > 0 && exp_q.size() > 0) begin
      got = push_q.pop_front();
      exp = exp_q.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stream_data: got %h want %h", got, exp);
      end
    end
    tick(1);
    n_cmp++;
    if (op_count !== exp_count) begin
      n_fail++;
      $display("FAIL stream_wrap_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    logic [OW-1:0] got, exp;
    clear_logs();
    in_q.push_back({2'b01, 12'h001, 12'h001});
    in_q.push_back({2'b01, 12'h002, 12'h002});
    in_q.push_back({2'b01, 12'h003, 12'h003});
    exp_q.push_back(25'h0000002);
    exp_q.push_back(25'h0000004);
    exp_q.push_back(25'h0000006);
    wait_ren(1, 30, ok);
    tick(1);
    enable = 1'b0;
    tick(30);
    n_cmp++;
    if (ren_cyc_q.size() != 1 || push_q.size() != 1 || in_q.size() != 2) begin
      n_fail++;
      $display("FAIL enable_drop: got reads=%0d pushes=%0d left=%0d want 1 1 2",
               ren_cyc_q.size(), push_q.size(), in_q.size());
    end
    enable = 1'b1;
    wait_pushes(3, 40, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL enable_resume: got %0d pushes want 3", push_q.size());
    end
    while (push_q.size() > 0 && exp_q.size() > 0) begin
      got = push_q.pop_front();
      exp = exp_q.pop_front();
      exp_count = exp_count + 1'b1;
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL enable_data: got %h want %h", got, exp);
      end
    end
  endtask

  task automatic test_reset_wait();
    bit ok;
    logic [OW-1:0] got;
    clear_logs();
    alu_delay = 0;
    in_q.push_back({2'b10, 12'h0AB, 12'h0CD});
    wait_ren(1, 30, ok);
    tick(4);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.r_en_in, bus.alu_start, bus.w_en_out, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstwait_controls: got %b want 0000", {bus.r_en_in, bus.alu_start, bus.w_en_out, busy});
    end
    n_cmp++;
    if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.fifo_out_data, op_count} !== 53'h0) begin
      n_fail++;
      $display("FAIL rstwait_data: got %h want 0", {bus.alu_op, bus.alu_a, bus.alu_b, bus.fifo_out_data, op_count});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    alu_delay = 1;
    tick(30);
    n_cmp++;
    if (push_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstwait_no_push: got %0d pushes want 0", push_q.size());
    end
    push_q.delete();
    in_q.push_back({2'b01, 12'h7FF, 12'h001});
    exp_count = exp_count + 1'b1;
    wait_pushes(1, 30, ok);
    got = ok ? push_q.pop_front() : 25'h1FFFFFF;
    n_cmp++;
    if (got !== 25'h0000800) begin
      n_fail++;
      $display("FAIL rstwait_next_data: got %h want %h", got, 25'h0000800);
    end
    tick(1);
    n_cmp++;
    if (op_count !== exp_count) begin
      n_fail++;
      $display("FAIL rstwait_next_count: got %0d want %0d", op_count, exp_count);
    end
  endtask

  initial begin
    bus.empty_in     = 1'b1;
    bus.fifo_in_data = '0;
    bus.alu_done     = 1'b0;
    bus.alu_result   = '0;
    bus.alu_ovf      = 1'b0;
    bus.full_out     = 1'b0;
    test_reset();
    test_add();
    test_illegal();
    test_timeout(0, 1'b0, 25'h1000000, 12'h00A, 12'h00B);
    test_timeout(TC, 1'b1, 25'h1000300, 12'h100, 12'h200);
    test_backpressure();
    test_stream_wrap();
    test_enable_drop();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
